// File: rtl/bsg_fpu_pkg.sv
// Shared FPU definitions: rounding modes and packed-word constants derived from
// the exponent/fraction widths.
package bsg_fpu_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,
    RM_RTZ = 2'd1,
    RM_RDN = 2'd2,
    RM_RUP = 2'd3
  } rm_e;

  // Constants are built wide and sliced by the user to the actual word width.
  localparam int unsigned FpMaxW = 64;

  // Quiet NaN magnitude: exponent all ones, fraction MSB set.
  function automatic logic [FpMaxW-1:0] canon_nan(input int unsigned e, input int unsigned m);
    logic [FpMaxW-1:0] r;
    r = ((FpMaxW'(1) << e) - FpMaxW'(1)) << m;
    r = r | (FpMaxW'(1) << (m - 1));
    return r;
  endfunction

  // Largest finite magnitude: exponent all ones except LSB, fraction all ones.
  function automatic logic [FpMaxW-1:0] max_finite(input int unsigned e, input int unsigned m);
    logic [FpMaxW-1:0] r;
    r = (FpMaxW'(1) << (e + m)) - FpMaxW'(1);
    r = r & ~(FpMaxW'(1) << m);
    return r;
  endfunction

endpackage

// File: rtl/bsg_fpu_rshift_sticky.sv
// Logical right shift that also reports whether any set bit was shifted out.
module bsg_fpu_rshift_sticky #(
  parameter int unsigned width_p     = 26,
  parameter int unsigned amt_width_p = 10
) (
  input  logic [width_p-1:0]     data_i,
  input  logic [amt_width_p-1:0] amt_i,
  output logic [width_p-1:0]     data_o,
  output logic                   sticky_o
);

  logic [width_p-1:0] lost_mask;

  always_comb begin
    lost_mask = ~({width_p{1'b1}} << amt_i);
    if (32'(amt_i) >= width_p) begin
      data_o   = '0;
      sticky_o = |data_i;
    end else begin
      data_o   = data_i >> amt_i;
      sticky_o = |(data_i & lost_mask);
    end
  end

endmodule

// File: rtl/bsg_fpu_pack_round.sv
// Denormalize, round and pack an unpacked FPU result into an IEEE-754 word.
// Two-stage elastic pipeline: valid/ready in, valid/yumi out.
module bsg_fpu_pack_round
  import bsg_fpu_pkg::*;
#(
  parameter int unsigned e_p = 8,
  parameter int unsigned m_p = 23
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             v_i,
  output logic             ready_o,
  input  logic             sign_i,
  input  logic [e_p+1:0]   exp_i,
  input  logic [m_p+2:0]   man_i,
  input  logic [1:0]       rm_i,
  input  logic             nan_i,
  input  logic             infty_i,
  input  logic             zero_i,
  output logic             v_o,
  input  logic             yumi_i,
  output logic [e_p+m_p:0] z_o,
  output logic             of_o,
  output logic             uf_o,
  output logic             nx_o
);

  localparam int unsigned ManW  = m_p + 3;
  localparam int unsigned ExpW  = e_p + 2;
  localparam int unsigned MagW  = e_p + m_p;
  localparam int unsigned WordW = MagW + 1;
  localparam logic [FpMaxW-1:0] NanWide = canon_nan(e_p, m_p);
  localparam logic [FpMaxW-1:0] MaxWide = max_finite(e_p, m_p);
  localparam logic [WordW-1:0]  NanWord = NanWide[WordW-1:0];
  localparam logic [MagW-1:0]   MaxMag  = MaxWide[MagW-1:0];
  localparam logic [ExpW-1:0]   ExpOvf  = ExpW'((1 << e_p) - 1);

  // Handshake
  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic s2_ready, s1_load, s2_load;

  assign s2_ready = ~s2_v_q | yumi_i;
  assign ready_o  = ~s1_v_q | s2_ready;
  assign s1_load  = v_i & ready_o;
  assign s2_load  = s1_v_q & s2_ready;
  assign v_o      = s2_v_q;

  always_comb begin
    s1_v_d = ready_o  ? v_i    : s1_v_q;
    s2_v_d = s2_ready ? s1_v_q : s2_v_q;
  end

  // Stage 1: denormalize
  logic            tiny_d, pre_of_d, lost;
  logic [ExpW-1:0] shamt;
  logic [ManW-1:0] man_sh;
  logic [e_p-1:0]  e_d;

  assign tiny_d   = exp_i[ExpW-1] | (exp_i == '0);
  assign pre_of_d = ~exp_i[ExpW-1] & (exp_i >= ExpOvf);
  assign shamt    = tiny_d ? (ExpW'(1) - exp_i) : '0;

  bsg_fpu_rshift_sticky #(
    .width_p    (ManW),
    .amt_width_p(ExpW)
  ) u_denorm (
    .data_i  (man_i),
    .amt_i   (shamt),
    .data_o  (man_sh),
    .sticky_o(lost)
  );

  // A tiny input always shifts by at least one, so the shifted hidden bit is
  // zero and doubles as the denormal exponent field.
  assign e_d = tiny_d ? {{(e_p-1){1'b0}}, man_sh[ManW-1]} : exp_i[e_p-1:0];

  logic           s1_sign_q, s1_g_q, s1_s_q, s1_tiny_q, s1_pre_of_q;
  logic           s1_nan_q, s1_infty_q, s1_zero_q;
  logic [e_p-1:0] s1_e_q;
  logic [m_p-1:0] s1_frac_q;
  rm_e            s1_rm_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_v_q      <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_e_q      <= '0;
      s1_frac_q   <= '0;
      s1_g_q      <= 1'b0;
      s1_s_q      <= 1'b0;
      s1_tiny_q   <= 1'b0;
      s1_pre_of_q <= 1'b0;
      s1_rm_q     <= RM_RNE;
      s1_nan_q    <= 1'b0;
      s1_infty_q  <= 1'b0;
      s1_zero_q   <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      if (s1_load) begin
        s1_sign_q   <= sign_i;
        s1_e_q      <= e_d;
        s1_frac_q   <= man_sh[ManW-2:2];
        s1_g_q      <= man_sh[1];
        s1_s_q      <= man_sh[0] | lost;
        s1_tiny_q   <= tiny_d;
        s1_pre_of_q <= pre_of_d;
        s1_rm_q     <= rm_e'(rm_i);
        s1_nan_q    <= nan_i;
        s1_infty_q  <= infty_i;
        s1_zero_q   <= zero_i;
      end
    end
  end

  // Stage 2: round and pack
  logic             inc, inexact, ovf, ovf_inf;
  logic [MagW:0]    sum;
  logic [e_p-1:0]   e_rnd;
  logic [WordW-1:0] z_d;
  logic             of_d, uf_d, nx_d;

  always_comb begin
    inexact = s1_g_q | s1_s_q;
    inc     = 1'b0;
    case (s1_rm_q)
      RM_RNE: inc = s1_g_q & (s1_s_q | s1_frac_q[0]);
      RM_RTZ: inc = 1'b0;
      RM_RDN: inc = s1_sign_q & inexact;
      RM_RUP: inc = ~s1_sign_q & inexact;
      default: inc = 1'b0;
    endcase
    // Carry out of the fraction ripples into the exponent field.
    sum     = {1'b0, s1_e_q, s1_frac_q} + (MagW+1)'(inc);
    e_rnd   = sum[MagW-1:m_p];
    ovf     = s1_pre_of_q | sum[MagW] | (&e_rnd);
    ovf_inf = (s1_rm_q == RM_RNE) | ((s1_rm_q == RM_RDN) & s1_sign_q)
            | ((s1_rm_q == RM_RUP) & ~s1_sign_q);

    z_d  = {s1_sign_q, sum[MagW-1:0]};
    of_d = 1'b0;
    uf_d = s1_tiny_q & inexact;
    nx_d = inexact;
    if (s1_nan_q) begin
      z_d  = NanWord;
      uf_d = 1'b0;
      nx_d = 1'b0;
    end else if (s1_infty_q) begin
      z_d  = {s1_sign_q, {e_p{1'b1}}, {m_p{1'b0}}};
      uf_d = 1'b0;
      nx_d = 1'b0;
    end else if (s1_zero_q) begin
      z_d  = {s1_sign_q, {MagW{1'b0}}};
      uf_d = 1'b0;
      nx_d = 1'b0;
    end else if (ovf) begin
      z_d  = ovf_inf ? {s1_sign_q, {e_p{1'b1}}, {m_p{1'b0}}} : {s1_sign_q, MaxMag};
      of_d = 1'b1;
      nx_d = 1'b1;
    end
  end

  logic [WordW-1:0] z_q;
  logic             of_q, uf_q, nx_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s2_v_q <= 1'b0;
      z_q    <= '0;
      of_q   <= 1'b0;
      uf_q   <= 1'b0;
      nx_q   <= 1'b0;
    end else begin
      s2_v_q <= s2_v_d;
      if (s2_load) begin
        z_q  <= z_d;
        of_q <= of_d;
        uf_q <= uf_d;
        nx_q <= nx_d;
      end
    end
  end

  assign z_o  = z_q;
  assign of_o = of_q;
  assign uf_o = uf_q;
  assign nx_o = nx_q;

endmodule

// File: tb/tb_bsg_fpu_pack_round.sv
// Directed-vector bench for bsg_fpu_pack_round (single precision).
module tb_bsg_fpu_pack_round;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        v_i, ready_o, sign_i;
  logic [9:0]  exp_i;
  logic [25:0] man_i;
  logic [1:0]  rm_i;
  logic        nan_i, infty_i, zero_i;
  logic        v_o, yumi_i;
  logic [31:0] z_o;
  logic        of_o, uf_o, nx_o;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  bsg_fpu_pack_round #(.e_p(8), .m_p(23)) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (v_i),
    .ready_o  (ready_o),
    .sign_i   (sign_i),
    .exp_i    (exp_i),
    .man_i    (man_i),
    .rm_i     (rm_i),
    .nan_i    (nan_i),
    .infty_i  (infty_i),
    .zero_i   (zero_i),
    .v_o      (v_o),
    .yumi_i   (yumi_i),
    .z_o      (z_o),
    .of_o     (of_o),
    .uf_o     (uf_o),
    .nx_o     (nx_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [9:0] e, input logic [25:0] m,
                       input logic [1:0] rm, input logic nan, input logic inf, input logic zero);
    sign_i  = s;
    exp_i   = e;
    man_i   = m;
    rm_i    = rm;
    nan_i   = nan;
    infty_i = inf;
    zero_i  = zero;
  endtask

  // One transaction with yumi_i high: accept, check latency, check result.
  task automatic run_vec(input string tag, input logic s, input logic [9:0] e,
                         input logic [25:0] m, input logic [1:0] rm,
                         input logic nan, input logic inf, input logic zero,
                         input logic [31:0] ez, input logic eof, input logic euf,
                         input logic enx);
    @(negedge clk_i);
    drive(s, e, m, rm, nan, inf, zero);
    v_i = 1'b1;
    #1 chk({tag, ".ready"}, 64'(ready_o), 64'd1);
    @(negedge clk_i);
    v_i = 1'b0;
    #1 chk({tag, ".v_early"}, 64'(v_o), 64'd0);
    @(negedge clk_i);
    #1;
    chk({tag, ".v_o"}, 64'(v_o), 64'd1);
    chk({tag, ".z"}, 64'(z_o), 64'(ez));
    chk({tag, ".of"}, 64'(of_o), 64'(eof));
    chk({tag, ".uf"}, 64'(uf_o), 64'(euf));
    chk({tag, ".nx"}, 64'(nx_o), 64'(enx));
  endtask

  logic [31:0] expq[$];
  logic [31:0] want;
  int          sent;

  initial begin
    reset_n_i = 1'b0;
    v_i       = 1'b0;
    yumi_i    = 1'b1;
    drive(1'b0, 10'd0, 26'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst.v_o", 64'(v_o), 64'd0);
    chk("rst.ready", 64'(ready_o), 64'd1);
    chk("rst.z", 64'(z_o), 64'd0);
    chk("rst.flags", 64'({of_o, uf_o, nx_o}), 64'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    //       tag         s     exp      man            rm    nan   inf   zero  z             of    uf    nx
    run_vec("one",      1'b0, 10'd127, 26'h2000000, 2'd0, 1'b0, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0);
    run_vec("tie_odd",  1'b0, 10'd127, 26'h2000006, 2'd0, 1'b0, 1'b0, 1'b0, 32'h3F800002, 1'b0, 1'b0, 1'b1);
    run_vec("tie_even", 1'b0, 10'd127, 26'h2000002, 2'd0, 1'b0, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b1);
    run_vec("mcarry",   1'b0, 10'd127, 26'h3FFFFFE, 2'd3, 1'b0, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b1);
    run_vec("rdn_neg",  1'b1, 10'd127, 26'h2000001, 2'd2, 1'b0, 1'b0, 1'b0, 32'hBF800001, 1'b0, 1'b0, 1'b1);
    run_vec("ovf_rtz",  1'b1, 10'd255, 26'h2000000, 2'd1, 1'b0, 1'b0, 1'b0, 32'hFF7FFFFF, 1'b1, 1'b0, 1'b1);
    run_vec("ovf_rne",  1'b1, 10'd255, 26'h2000000, 2'd0, 1'b0, 1'b0, 1'b0, 32'hFF800000, 1'b1, 1'b0, 1'b1);
    run_vec("ovf_rup",  1'b1, 10'd300, 26'h2000000, 2'd3, 1'b0, 1'b0, 1'b0, 32'hFF7FFFFF, 1'b1, 1'b0, 1'b1);
    run_vec("rnd_ovf",  1'b0, 10'd254, 26'h3FFFFFE, 2'd0, 1'b0, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b1);
    run_vec("denorm",   1'b0, 10'h3FF, 26'h2000000, 2'd0, 1'b0, 1'b0, 1'b0, 32'h00200000, 1'b0, 1'b0, 1'b0);
    run_vec("flush",    1'b0, 10'h3E2, 26'h2000000, 2'd0, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1);
    run_vec("to_minnm", 1'b0, 10'd0,   26'h3FFFFFF, 2'd0, 1'b0, 1'b0, 1'b0, 32'h00800000, 1'b0, 1'b1, 1'b1);
    run_vec("nan_inf",  1'b1, 10'd127, 26'h2000003, 2'd0, 1'b1, 1'b1, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1'b0);
    run_vec("inf_neg",  1'b1, 10'd255, 26'h2000003, 2'd0, 1'b0, 1'b1, 1'b1, 32'hFF800000, 1'b0, 1'b0, 1'b0);
    run_vec("zero_neg", 1'b1, 10'h3E2, 26'h0000003, 2'd3, 1'b0, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b0, 1'b0);

    // Backpressure: yumi_i low for three cycles while four inputs are offered.
    sent = 0;
    for (int cyc = 0; cyc < 40 && (sent < 4 || expq.size() > 0); cyc++) begin
      @(negedge clk_i);
      yumi_i = (cyc >= 3);
      v_i    = (sent < 4);
      drive(1'b0, 10'(127 + sent), 26'h2000000, 2'd0, 1'b0, 1'b0, 1'b0);
      #1;
      if (cyc == 2) chk("bp.ready_low", 64'(ready_o), 64'd0);
      if (v_o && !yumi_i) chk("bp.hold", 64'(z_o), 64'(expq[0]));
      if (v_o && yumi_i) begin
        want = expq.pop_front();
        chk("bp.order", 64'(z_o), 64'(want));
      end
      if (v_i && ready_o) begin
        expq.push_back({1'b0, 8'(127 + sent), 23'd0});
        sent++;
      end
    end
    chk("bp.drained", 64'(expq.size()), 64'd0);
    chk("bp.sent", 64'(sent), 64'd4);

    // Asynchronous reset with both stages occupied.
    @(negedge clk_i);
    v_i    = 1'b0;
    yumi_i = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      v_i = 1'b1;
      drive(1'b0, 10'd130, 26'h2000000, 2'd0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk_i);
    v_i = 1'b0;
    #1 chk("ar.full", 64'({v_o, ready_o}), 64'b10);
    #2 reset_n_i = 1'b0;
    #1;
    chk("ar.v_drop", 64'(v_o), 64'd0);
    chk("ar.ready", 64'(ready_o), 64'd1);
    chk("ar.z_clr", 64'(z_o), 64'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    yumi_i    = 1'b1;
    @(negedge clk_i);
    #1;
    chk("ar.post_v", 64'(v_o), 64'd0);
    chk("ar.post_ready", 64'(ready_o), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
